// File: rtl/branch_target_predictor_if.sv
// Lookup (IF) and resolve/train (EX) signal bundle for the branch target predictor.
// master = pipeline side, slave = predictor side.
interface branch_target_predictor_if;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_pred_taken;
  logic [31:0] update_pred_target;
  logic        invalidate;
  logic        mispredict;

  modport master (
    output lookup_pc, update_en, update_pc, update_taken,
    output update_target, update_pred_taken, update_pred_target,
    output invalidate,
    input  pred_hit, pred_taken, pred_target, mispredict
  );

  modport slave (
    input  lookup_pc, update_en, update_pc, update_taken,
    input  update_target, update_pred_taken, update_pred_target,
    input  invalidate,
    output pred_hit, pred_taken, pred_target, mispredict
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with saturating direction counters for the IF stage.
// Define BTB_BYPASS_EN to forward a same-cycle update of the looked-up entry.
module branch_target_predictor #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 10,
  parameter int CTR_W   = 2
) (
  input logic clk,
  input logic rst_n,
  branch_target_predictor_if.slave btb
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [CTR_W-1:0] ctr_t;

  logic        valid [ENTRIES];
  tag_t        tags  [ENTRIES];
  logic [31:0] tgts  [ENTRIES];
  ctr_t        ctrs  [ENTRIES];

  idx_t l_idx;
  idx_t u_idx;
  tag_t l_tag;
  tag_t u_tag;

  assign l_idx = btb.lookup_pc[IDX_W+1:2];
  assign l_tag = btb.lookup_pc[IDX_W+1+TAG_W:IDX_W+2];
  assign u_idx = btb.update_pc[IDX_W+1:2];
  assign u_tag = btb.update_pc[IDX_W+1+TAG_W:IDX_W+2];

  logic unused;
  assign unused = ^{btb.update_pc[1:0],
                    btb.update_pc[31:IDX_W+2+TAG_W]};

  logic        u_hit;
  logic        wr_en;
  ctr_t        u_ctr;
  ctr_t        wr_ctr;
  logic [31:0] wr_tgt;

  assign u_ctr = ctrs[u_idx];
  assign u_hit = valid[u_idx] && (tags[u_idx] == u_tag);
  // A not-taken miss never allocates, so it leaves the table alone
  assign wr_en = btb.update_en && (u_hit || btb.update_taken);
  assign wr_tgt = btb.update_taken ? btb.update_target : tgts[u_idx];

  always_comb begin
    wr_ctr = u_ctr;
    unique case (1'b1)
      !u_hit:
        wr_ctr = CTR_WT;
      u_hit && btb.update_taken && (u_ctr != CTR_MAX):
        wr_ctr = u_ctr + CTR_W'(1);
      u_hit && !btb.update_taken && (u_ctr != '0):
        wr_ctr = u_ctr - CTR_W'(1);
      default:
        wr_ctr = u_ctr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        tags[i]  <= '0;
        tgts[i]  <= '0;
        ctrs[i]  <= CTR_WNT;
      end
    end else if (btb.invalidate) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
      end
    end else if (wr_en) begin
      valid[u_idx] <= 1'b1;
      tags[u_idx]  <= u_tag;
      tgts[u_idx]  <= wr_tgt;
      ctrs[u_idx]  <= wr_ctr;
    end
  end

  logic        r_hit;
  ctr_t        r_ctr;
  logic [31:0] r_tgt;

  always_comb begin
    r_hit = valid[l_idx] && (tags[l_idx] == l_tag);
    r_ctr = ctrs[l_idx];
    r_tgt = tgts[l_idx];
`ifdef BTB_BYPASS_EN
    if (rst_n && wr_en && !btb.invalidate &&
        (u_idx == l_idx) && (u_tag == l_tag)) begin
      r_hit = 1'b1;
      r_ctr = wr_ctr;
      r_tgt = wr_tgt;
    end
`endif
  end

  assign btb.pred_hit    = r_hit;
  assign btb.pred_taken  = r_hit && r_ctr[CTR_W-1];
  assign btb.pred_target = btb.pred_taken ? r_tgt
                                          : btb.lookup_pc + 32'd4;

  assign btb.mispredict = rst_n && btb.update_en &&
    ((btb.update_taken != btb.update_pred_taken) ||
     (btb.update_taken &&
      (btb.update_target != btb.update_pred_target)));
endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomised self-checking bench for branch_target_predictor against
// an arithmetic reference model of the table.
module tb_branch_target_predictor;
  localparam int ENT  = 16;
  localparam int IDXB = 4;
  localparam int TAGW = 10;
  localparam int CTRW = 2;
  localparam int CMAX = (1 << CTRW) - 1;
  localparam int CWT  = 1 << (CTRW - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_target_predictor_if bus ();

  branch_target_predictor #(
    .ENTRIES(ENT), .TAG_W(TAGW), .CTR_W(CTRW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btb(bus.slave)
  );

  int nerr = 0;
  int nchk = 0;

  bit          m_v   [ENT];
  int unsigned m_tag [ENT];
  logic [31:0] m_tgt [ENT];
  int          m_ctr [ENT];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned f_idx(input logic [31:0] pc);
    return (pc >> 2) % ENT;
  endfunction

  function automatic int unsigned f_tag(input logic [31:0] pc);
    return (pc >> (2 + IDXB)) % (1 << TAGW);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < ENT; i++) begin
      m_v[i] = 0;
      m_ctr[i] = CWT - 1;
      m_tgt[i] = 32'h0;
      m_tag[i] = 0;
    end
  endfunction

  function automatic void m_next(input logic [31:0] upc,
                                 input logic [31:0] ut,
                                 input logic tk,
                                 output bit wr,
                                 output int nc,
                                 output logic [31:0] nt);
    int unsigned i = f_idx(upc);
    bit hit = m_v[i] && (m_tag[i] == f_tag(upc));
    wr = 0; nc = 0; nt = 32'h0;
    if (hit) begin
      wr = 1;
      if (tk) nc = (m_ctr[i] < CMAX) ? m_ctr[i] + 1 : m_ctr[i];
      else    nc = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      nt = tk ? ut : m_tgt[i];
    end else if (tk) begin
      wr = 1; nc = CWT; nt = ut;
    end
  endfunction

  task automatic check_outs(input string name);
    logic [31:0] lpc = bus.lookup_pc;
    int unsigned i = f_idx(lpc);
    bit hit = m_v[i] && (m_tag[i] == f_tag(lpc));
    int ctr = m_ctr[i];
    logic [31:0] tgt = m_tgt[i];
    bit tk;
    bit mp = 0;
    logic [31:0] ptgt;
`ifdef BTB_BYPASS_EN
    if (bus.update_en && !bus.invalidate &&
        f_idx(bus.update_pc) == i &&
        f_tag(bus.update_pc) == f_tag(lpc)) begin
      bit wr; int nc; logic [31:0] nt;
      m_next(bus.update_pc, bus.update_target, bus.update_taken,
             wr, nc, nt);
      if (wr) begin hit = 1; ctr = nc; tgt = nt; end
    end
`endif
    tk = hit && (ctr >= CWT);
    ptgt = tk ? tgt : lpc + 32'd4;
    if (bus.update_en)
      mp = (bus.update_taken != bus.update_pred_taken) ||
           (bus.update_taken &&
            bus.update_target != bus.update_pred_target);
    chk({name, ".hit"}, 32'(bus.pred_hit), 32'(hit));
    chk({name, ".taken"}, 32'(bus.pred_taken), 32'(tk));
    chk({name, ".target"}, bus.pred_target, ptgt);
    chk({name, ".mispredict"}, 32'(bus.mispredict), 32'(mp));
  endtask

  task automatic cyc(input string name,
                     input logic [31:0] lpc, input logic uen,
                     input logic [31:0] upc, input logic tk,
                     input logic [31:0] ut, input logic ptk,
                     input logic [31:0] ptgt, input logic inv);
    bit wr; int nc; logic [31:0] nt;
    @(negedge clk);
    bus.lookup_pc = lpc;
    bus.update_en = uen;
    bus.update_pc = upc;
    bus.update_taken = tk;
    bus.update_target = ut;
    bus.update_pred_taken = ptk;
    bus.update_pred_target = ptgt;
    bus.invalidate = inv;
    #1;
    check_outs(name);
    @(posedge clk);
    if (inv) begin
      for (int i = 0; i < ENT; i++) m_v[i] = 0;
    end else if (uen) begin
      m_next(upc, ut, tk, wr, nc, nt);
      if (wr) begin
        m_v[f_idx(upc)] = 1;
        m_tag[f_tag(upc) == 0 ? f_idx(upc) : f_idx(upc)] = f_tag(upc);
        m_tgt[f_idx(upc)] = nt;
        m_ctr[f_idx(upc)] = nc;
      end
    end
  endtask

  task automatic look(input string name, input logic [31:0] lpc);
    cyc(name, lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] pc;
    pc = (32'($urandom_range(0, 2)) << 6) |
         (32'($urandom_range(0, 15)) << 2) |
         32'($urandom_range(0, 3));
    if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC | (pc & 32'h3);
    return pc;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lpc, upc, ut, ptgt;
    logic uen, tk, ptk, inv;
    m_reset();
    bus.lookup_pc = 32'h0;
    bus.update_en = 1'b0;
    bus.update_pc = 32'h0;
    bus.update_taken = 1'b0;
    bus.update_target = 32'h0;
    bus.update_pred_taken = 1'b0;
    bus.update_pred_target = 32'h0;
    bus.invalidate = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    look("reset", 32'h40);
    cyc("alloc", 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h0, 0);
    look("alloc_hit", 32'h40);
    cyc("nt1", 32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h100, 0);
    cyc("nt2", 32'h40, 1, 32'h40, 0, 32'h0, 0, 32'h0, 0);
    look("ctr00", 32'h40);
    cyc("nt3", 32'h40, 1, 32'h40, 0, 32'h0, 0, 32'h0, 0);
    for (int k = 0; k < 4; k++)
      cyc("tk_sat", 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h0, 0);
    look("ctr11", 32'h40);
    cyc("alias", 32'h40, 1, 32'h440, 1, 32'h200, 1, 32'h200, 0);
    look("alias_old", 32'h40);
    look("alias_new", 32'h440);
    cyc("inv", 32'h40, 1, 32'h80, 1, 32'h180, 1, 32'h180, 1);
    look("inv_40", 32'h40);
    look("inv_80", 32'h80);
    cyc("pre_rst", 32'h80, 1, 32'h80, 1, 32'h180, 0, 32'h0, 0);

    @(negedge clk);
    bus.lookup_pc = 32'h80;
    bus.update_en = 1'b1;
    bus.update_pc = 32'h80;
    bus.update_taken = 1'b0;
    bus.update_target = 32'h0;
    bus.update_pred_taken = 1'b1;
    bus.update_pred_target = 32'h180;
    bus.invalidate = 1'b0;
    #1;
    check_outs("pre_async");
    #1 rst_n = 1'b0;
    #1;
    m_reset();
    chk("async.hit", 32'(bus.pred_hit), 32'h0);
    chk("async.target", bus.pred_target, 32'h84);
    chk("async.mispredict", 32'(bus.mispredict), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.update_en = 1'b0;
    look("post_rst", 32'h80);

    cyc("bypass", 32'h40, 1, 32'h40, 1, 32'h300, 0, 32'h0, 0);
    look("bypass_after", 32'h40);
    look("wrap", 32'hFFFF_FFFC);

    for (int n = 0; n < 400; n++) begin
      lpc = rnd_pc();
      uen = ($urandom_range(0, 2) != 0);
      upc = ($urandom_range(0, 2) == 0) ? lpc : rnd_pc();
      tk = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: ut = 32'h100;
        1: ut = 32'h200;
        2: ut = 32'h300;
        default: ut = $urandom & 32'hFFFF_FFFC;
      endcase
      ptk = ($urandom_range(0, 3) != 0) ? tk : ~tk;
      ptgt = ($urandom_range(0, 1) != 0) ? ut : 32'h400;
      inv = ($urandom_range(0, 24) == 0);
      if (!uen) begin
        upc = 'x; tk = 'x; ut = 'x; ptk = 'x; ptgt = 'x;
      end
      cyc("rand", lpc, uen, upc, tk, ut, ptk, ptgt, inv);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised direct-mapped branch target buffer with per-entry saturating direction counters, placed in the IF stage of the pipelined MIPS core.
- IF looks up the current PC combinationally and gets a predicted next PC.
- EX returns the resolved branch outcome; the block trains its table and flags a mispredict for the flush logic.
- Generalises the static "predict not-taken, resolve in EX" scheme: table depth, tag width and counter width are configurable.

Parameters:
ENTRIES, 16, number of table entries; power of two, minimum 2; IDX_W = log2(ENTRIES)
TAG_W, 10, stored tag bits, taken from pc[IDX_W+1+TAG_W : IDX_W+2]
CTR_W, 2, direction counter width, minimum 1

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
lookup_pc  in  32  IF-stage PC
pred_hit  out  1  valid entry with matching tag
pred_taken  out  1  predicted taken
pred_target  out  32  predicted next PC
update_en  in  1  EX stage resolving a branch or jump this cycle
update_pc  in  32  PC of the resolving instruction
update_taken  in  1  actual outcome
update_target  in  32  actual taken target
update_pred_taken  in  1  prediction carried down the pipe with the instruction
update_pred_target  in  32  predicted target carried down the pipe
invalidate  in  1  clear whole table (synchronous)
mispredict  out  1  resolved outcome differs from prediction

Behaviour:
- Index and tag: idx = pc[IDX_W+1:2]; tag = pc[IDX_W+1+TAG_W:IDX_W+2]. Bits [1:0] are ignored.
- Per-entry state: valid, tag, 32-bit target, CTR_W-bit counter.
- Asynchronous reset (rst_n low) clears immediately, with no clock edge needed:
  - all valid = 0, counters = 2^(CTR_W-1)-1 (weakly not-taken), targets = 0.
  - Outputs follow at once: pred_hit = 0, pred_taken = 0, pred_target = lookup_pc+4, mispredict = 0.
- Lookup is combinational, zero latency:
  - hit = valid[idx] && tag match.
  - pred_taken = hit && counter MSB.
  - pred_target = pred_taken ? target[idx] : lookup_pc+4 (modulo 2^32, wraps at 0xFFFFFFFC).
- mispredict is combinational: update_en && ((update_taken != update_pred_taken) || (update_taken && update_target != update_pred_target)). It is 0 when update_en = 0.
- Update happens at posedge clk when update_en = 1:
  - Entry hit: counter +1 if taken, -1 if not taken, saturating at 0 and 2^CTR_W-1. Target is overwritten only when taken.
  - Miss and taken: allocate the entry, replacing any aliased entry. Set valid = 1, new tag, target = update_target, counter = 2^(CTR_W-1) (weakly taken).
  - Miss and not taken: no state change.
- invalidate at posedge clears all valid bits and takes priority over a same-cycle update; that update is discarded. Counters and targets are left unchanged.
- Same-cycle update and lookup of the same idx: lookup returns the pre-edge contents, except as described under the optional feature.
- Reset asserted mid-operation: any in-flight update is lost and the table is cleared.
- X on update inputs while update_en = 0 must not corrupt state.

Optional Feature:
- Macro: BTB_BYPASS_EN.
- When defined: if update_en && !invalidate and update_pc maps to the same idx and tag as lookup_pc, the outputs reflect the post-update entry in the same cycle:
  - hit = 1 if the entry exists or is being allocated.
  - Counter and target are the values that will be written.
- When undefined: lookup always reads the stored table only.
- Port list and all other behaviour are identical in both cases.

Test Plan:
1. Reset, then lookup_pc = 0x00000040 -> pred_hit = 0, pred_taken = 0, pred_target = 0x00000044, mispredict = 0.
2. Update pc = 0x40, taken, target = 0x100, pred_taken = 0 -> mispredict = 1 that cycle. Next cycle lookup 0x40 -> hit = 1, taken = 1, target = 0x100.
3. From scenario 2, two not-taken updates on 0x40 -> counter 10→01→00. Lookup gives hit = 1, taken = 0, target = 0x44. A third not-taken keeps 00. Then four taken updates -> 01, 10, 11, 11 (saturates).
4. Alias: update pc = 0x440 (idx 0, tag 0x011), taken, target = 0x200 -> lookup 0x40 gives hit = 0, target 0x44; lookup 0x440 gives hit = 1, target 0x200.
5. invalidate = 1 with a same-cycle taken update to 0x80 -> next cycle lookups of 0x40 and 0x80 both give hit = 0. Separately, drive rst_n low between edges -> pred_hit falls to 0 with no clock edge.
6. Same cycle: taken update to 0x40 (target 0x300) and lookup 0x40 on an empty table -> with BTB_BYPASS_EN: hit = 1, target 0x300; without: hit = 0, target 0x44.
